// File: rtl/dual_port_ram2_pkg.sv
// Shared definitions for the byte-write / word-read dual-port RAM.
// Holds the default geometry, the byte-lane constants, the controller state
// type and the lane decode helper used by the top level.
package dual_port_ram2_pkg;

    // Default geometry: 2048 bytes seen as 512 words of 4 byte lanes.
    localparam int ADDRA_W_DEF  = 11;
    localparam int ADDRB_W_DEF  = 9;
    localparam int DATA_B_W_DEF = 32;

    // Byte-lane organisation of a port B word.
    localparam int LANES      = 4;
    localparam int LANE_W     = 8;
    localparam int LANE_SEL_W = 2;

    // Controller state: CLEAR runs once after every reset, IDLE is terminal.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // One-hot lane enable for a port A byte select (little-endian lane order).
    function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_SEL_W-1:0] sel);
        lane_onehot = LANES'(1) << sel;
    endfunction

endpackage : dual_port_ram2_pkg

// File: rtl/dpram_lane_512x8.sv
// One byte lane of the RAM: 512 x 8 storage with a single write port
// (byte enable) and a synchronous read-first read port on the same clock.
// Maps onto a block RAM primitive, so neither the array nor the read
// register carries a reset; the top level gates the read data instead.
module dpram_lane_512x8 #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              be_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // NOTE: the storage array has no reset; resetting a memory turns it into
    // thousands of flops and prevents block RAM inference. Its contents are
    // defined by the clear engine in the top level.
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write the enabled byte and register the read word every cycle.
    // NOTE: both updates are non-blocking, so a read of the location being
    // written at the same edge returns the old contents (read-first).
    always_ff @(posedge clk) begin
        if (be_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule : dpram_lane_512x8

// File: rtl/dual_port_ram2.sv
// Dual-port RAM with an 8-bit write port A (byte address) and a 32-bit
// registered read port B (word address) on one clock. After every reset a
// clear engine zeroes all 512 words, one word per cycle, with busy high;
// port A writes are dropped and dob reads as zero while it runs.
module dual_port_ram2
    import dual_port_ram2_pkg::*;
#(
    parameter int ADDRA_W  = ADDRA_W_DEF,
    parameter int ADDRB_W  = ADDRB_W_DEF,
    parameter int DATA_B_W = DATA_B_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wea,
    input  logic [ADDRA_W-1:0]  addra,
    input  logic [LANE_W-1:0]   dia,
    input  logic [ADDRB_W-1:0]  addrb,
    output logic [DATA_B_W-1:0] dob,
    output logic                busy
);

    // ------------------------------------------------------------------
    // Port A decode: upper bits pick the word, the low two bits the lane.
    // ------------------------------------------------------------------
    logic [ADDRB_W-1:0]    a_word;
    logic [LANE_SEL_W-1:0] a_lane;

    assign a_word = addra[ADDRA_W-1:LANE_SEL_W];
    assign a_lane = addra[LANE_SEL_W-1:0];

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [ADDRB_W-1:0] clr_cnt_q, clr_cnt_d;
    logic               rd_valid_q, rd_valid_d;

    // Next-state logic: walk the clear counter to the last word, then idle.
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == '1) begin
                    // Last word is cleared at this edge; counter holds, no wrap.
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDRB_W'(1);
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Read data becomes visible only for reads captured while idle: the read
    // taken on the final clear edge is read-first and may see stale contents.
    assign rd_valid_d = (state_q == IDLE);

    // State, clear counter and read-valid registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign busy = (state_q == CLEAR);

    // ------------------------------------------------------------------
    // Write muxing: the clear engine owns all four lanes while clearing,
    // port A owns the single addressed lane afterwards.
    // ------------------------------------------------------------------
    logic [ADDRB_W-1:0] wr_addr;
    logic [LANE_W-1:0]  wr_data;
    logic [LANES-1:0]   lane_we;

    // Select the write source and the per-lane byte enables.
    always_comb begin
        wr_addr = a_word;
        wr_data = dia;
        lane_we = '0;
        if (state_q == CLEAR) begin
            wr_addr = clr_cnt_q;
            wr_data = '0;
            lane_we = '1;
        end else if (wea) begin
            lane_we = lane_onehot(a_lane);
        end
    end

    // ------------------------------------------------------------------
    // Byte lanes
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] lane_rdata [LANES];

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        dpram_lane_512x8 #(
            .ADDR_W (ADDRB_W),
            .DATA_W (LANE_W)
        ) u_lane (
            .clk     (clk),
            .be_i    (lane_we[n]),
            .waddr_i (wr_addr),
            .wdata_i (wr_data),
            .raddr_i (addrb),
            .rdata_o (lane_rdata[n])
        );
    end

    // ------------------------------------------------------------------
    // dob register stage: the lane read registers gated by the read-valid
    // flop, so reset forces dob to zero immediately and it stays zero
    // through the clear sequence.
    // ------------------------------------------------------------------
    logic [DATA_B_W-1:0] rd_word;

    // Assemble the port B word, lane n on bits [8n+7:8n].
    always_comb begin
        rd_word = '0;
        for (int n = 0; n < LANES; n++) begin
            rd_word[n*LANE_W +: LANE_W] = lane_rdata[n];
        end
    end

    assign dob = rd_valid_q ? rd_word : '0;

endmodule : dual_port_ram2

// File: tb/tb_dual_port_ram2.sv
// Self-checking bench for dual_port_ram2: directed vector table for the
// single-cycle behaviour plus hand sequences for clear, reset and timing.
`timescale 1ns/1ps
module tb_dual_port_ram2;

    logic        clk;
    logic        rst_n;
    logic        wea;
    logic [10:0] addra;
    logic [7:0]  dia;
    logic [8:0]  addrb;
    logic [31:0] dob;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    dual_port_ram2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wea   (wea),
        .addra (addra),
        .dia   (dia),
        .addrb (addrb),
        .dob   (dob),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [10:0] a;
        logic [7:0]  d;
        logic [8:0]  b;
        logic [31:0] exp_dob;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) for busy to drop; returns cycles spent and the OR of dob
    // sampled while busy was high.
    task automatic wait_idle(output int cycles, output logic [31:0] dob_or);
        cycles = 0;
        dob_or = '0;
        while (busy === 1'b1 && cycles < 1000) begin
            dob_or = dob_or | dob;
            @(negedge clk);
            cycles++;
        end
    endtask

    // Port A write with wea high only for a half-cycle window around the edge.
    task automatic pulse_write(input logic [10:0] a, input logic [7:0] d);
        addra = a;
        dia   = d;
        #2 wea = 1'b1;
        @(posedge clk);
        #2 wea = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cycles;
        logic [31:0] dob_or;

        // Read-first vectors: exp_dob is the word at b before this cycle's write.
        vecs[0]  = '{1'b1, 11'd0,    8'h21, 9'd0,   32'h0000_0000};
        vecs[1]  = '{1'b1, 11'd1,    8'h43, 9'd0,   32'h0000_0021};
        vecs[2]  = '{1'b1, 11'd2,    8'h65, 9'd0,   32'h0000_4321};
        vecs[3]  = '{1'b1, 11'd3,    8'h87, 9'd0,   32'h0065_4321};
        vecs[4]  = '{1'b0, 11'd0,    8'h00, 9'd0,   32'h8765_4321};
        vecs[5]  = '{1'b0, 11'd0,    8'h00, 9'd0,   32'h8765_4321};
        vecs[6]  = '{1'b1, 11'd1,    8'hAA, 9'd0,   32'h8765_4321};
        vecs[7]  = '{1'b0, 11'd1,    8'hAA, 9'd0,   32'h8765_AA21};
        vecs[8]  = '{1'b1, 11'd2047, 8'h11, 9'd511, 32'h0000_0000};
        vecs[9]  = '{1'b0, 11'd0,    8'h00, 9'd511, 32'h1100_0000};
        vecs[10] = '{1'b0, 11'd0,    8'h00, 9'd10,  32'h0000_0000};
        vecs[11] = '{1'b1, 11'h400,  8'h33, 9'd256, 32'h0000_0000};
        vecs[12] = '{1'b0, 11'h401,  8'hFF, 9'd256, 32'h0000_0033};
        vecs[13] = '{1'b0, 11'h401,  8'hFF, 9'd256, 32'h0000_0033};

        rst_n = 1'b0;
        wea   = 1'b0;
        addra = '0;
        dia   = '0;
        addrb = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd1);
        check("reset_dob", dob, 32'h0);

        // Initial clear: 512 busy cycles, dob zero throughout.
        rst_n = 1'b1;
        wait_idle(cycles, dob_or);
        check("clear_len", cycles, 32'd512);
        check("clear_dob", dob_or, 32'h0);

        // Whole memory reads zero after clear.
        for (int i = 0; i < 512; i++) begin
            addrb = 9'(i);
            @(negedge clk);
            check($sformatf("zero_w%0d", i), dob, 32'h0);
        end

        // Vector table.
        for (int i = 0; i < NVEC; i++) begin
            wea   = vecs[i].wr;
            addra = vecs[i].a;
            dia   = vecs[i].d;
            addrb = vecs[i].b;
            @(negedge clk);
            check($sformatf("vec%0d", i), dob, vecs[i].exp_dob);
        end
        wea = 1'b0;

        // Half-cycle wea pulses into word 1.
        addrb = 9'd10;
        pulse_write(11'd4, 8'h21);
        pulse_write(11'd5, 8'h43);
        pulse_write(11'd6, 8'h65);
        pulse_write(11'd7, 8'h87);
        addrb = 9'd1;
        @(negedge clk);
        check("pulse_w1", dob, 32'h8765_4321);
        addrb = 9'd10;
        @(negedge clk);
        check("pulse_w10", dob, 32'h0);

        // Top byte via addra 2047, then reset in the middle of a clear.
        wea   = 1'b1;
        addra = 11'd2047;
        dia   = 8'h5A;
        addrb = 9'd511;
        @(negedge clk);
        wea = 1'b0;
        @(negedge clk);
        check("w511_before", dob, 32'h5A00_0000);

        #1 rst_n = 1'b0;
        #1;
        check("async_rst_dob", dob, 32'h0);
        check("async_rst_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("busy_mid_clear", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(cycles, dob_or);
        check("reclear_len", cycles, 32'd512);
        check("reclear_dob", dob_or, 32'h0);
        addrb = 9'd511;
        @(negedge clk);
        check("w511_after", dob, 32'h0);

        // Port A writes attempted throughout the clear are dropped.
        wea   = 1'b1;
        addra = 11'd0;
        dia   = 8'h12;
        addrb = 9'd0;
        @(negedge clk);
        wea = 1'b0;
        @(negedge clk);
        check("w0_before", dob, 32'h0000_0012);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wea   = 1'b1;
        addra = 11'd0;
        dia   = 8'hFF;
        wait_idle(cycles, dob_or);
        wea = 1'b0;
        check("busywr_len", cycles, 32'd512);
        check("busywr_dob", dob_or, 32'h0);
        @(negedge clk);
        check("busywr_w0", dob, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dual_port_ram2
